// File: rtl/alu_txn_driver.sv
// Command FIFO plus issue/response tracker that drives a 4-bit ALU through its
// valid_in/valid_out handshake, with watchdog and spurious-response detection.
package macro_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7
  } opcode_e;
endpackage

// state   | meaning
// IDLE    | nothing issued
// RUN     | issuing from the FIFO while enable is high
// DRAIN   | enable dropped, waiting for outstanding responses
// TIMEOUT | watchdog expired, halted until clear
module alu_txn_driver
  import macro_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_cin,
  input  opcode_e          cmd_ctl,
  output logic             dut_reset,
  output logic             valid_in,
  output logic             cin,
  output logic [3:0]       a,
  output logic [3:0]       b,
  output opcode_e          ctl,
  input  logic             valid_out,
  input  logic             carry,
  input  logic             zero,
  input  logic [3:0]       alu,
  output logic             rsp_valid,
  output logic [3:0]       rsp_alu,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_spurious,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0]      MAX_OUT_V = 4'(MAX_OUT);
  localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    opcode_e    ctl;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_TIMEOUT} state_e;

  state_e          state;
  cmd_t            mem [FIFO_DEPTH];
  cmd_t            head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]  count;
  logic [3:0]      outstanding;
  logic [WD_W-1:0] wd;
  logic            dut_reset_q;
  logic            full, empty, push, pop, wd_hit, spurious;

  assign full      = (count == FIFO_FULL);
  assign empty     = (count == '0);
  assign cmd_ready = !full && !clear && (state != S_TIMEOUT);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign spurious  = valid_out && (outstanding == '0);
  // Down-counter expiry: the next edge would be the TIMEOUT-th silent cycle.
  assign wd_hit    = (outstanding != '0) && !valid_out && (wd == WD_W'(1));
  assign pop       = (state == S_RUN) && enable && !empty &&
                     (outstanding < MAX_OUT_V) && !clear && !wd_hit;
  assign dut_reset = reset | dut_reset_q;
  assign busy      = (state == S_RUN) || (state == S_DRAIN) || (outstanding != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, cin: cmd_cin, ctl: cmd_ctl};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W + 1)'(1);
      else if (pop && !push) count <= count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      valid_in     <= 1'b0;
      a            <= '0;
      b            <= '0;
      cin          <= 1'b0;
      ctl          <= opcode_e'(0);
      rsp_valid    <= 1'b0;
      rsp_alu      <= '0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      issued_cnt   <= '0;
      done_cnt     <= '0;
      outstanding  <= '0;
      wd           <= WD_RELOAD;
      dut_reset_q  <= 1'b0;
    end else begin
      dut_reset_q <= clear;
      rsp_valid   <= valid_out;
      if (valid_out) begin
        rsp_alu   <= alu;
        rsp_carry <= carry;
        rsp_zero  <= zero;
      end
      if (clear) begin
        state        <= S_IDLE;
        valid_in     <= 1'b0;
        err_timeout  <= 1'b0;
        err_spurious <= 1'b0;
        issued_cnt   <= '0;
        done_cnt     <= '0;
        outstanding  <= '0;
        wd           <= WD_RELOAD;
      end else begin
        valid_in <= pop;
        if (pop) begin
          a          <= head.a;
          b          <= head.b;
          cin        <= head.cin;
          ctl        <= head.ctl;
          issued_cnt <= issued_cnt + CNT_W'(1);
        end
        if (valid_out) done_cnt <= done_cnt + CNT_W'(1);
        if (spurious) err_spurious <= 1'b1;

        // Spurious responses never decrement; they were never counted in.
        if (pop && !(valid_out && !spurious))      outstanding <= outstanding + 4'd1;
        else if (!pop && valid_out && !spurious)   outstanding <= outstanding - 4'd1;

        if (valid_out || (outstanding == '0)) wd <= WD_RELOAD;
        else if (wd != '0)                    wd <= wd - WD_W'(1);

        if (wd_hit) begin
          state       <= S_TIMEOUT;
          err_timeout <= 1'b1;
        end else begin
          case (state)
            S_IDLE:  if (enable) state <= S_RUN;
            S_RUN:   if (!enable) state <= (outstanding != '0) ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
              if (enable)                  state <= S_RUN;
              else if (outstanding == '0)  state <= S_IDLE;
            end
            default: state <= S_TIMEOUT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_txn_driver.sv
// Directed bench for alu_txn_driver: a queue-based transaction model checked
// every cycle, plus literal expectations for each scenario.
module tb_alu_txn_driver;
  import macro_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUT    = 4;
  localparam int TIMEOUT    = 16;
  localparam int CNT_W      = 16;

  logic clk = 1'b0;
  logic reset, enable, clear, cmd_valid, cmd_ready, cmd_cin;
  logic [3:0] cmd_a, cmd_b, a, b, alu, rsp_alu;
  opcode_e cmd_ctl, ctl;
  logic dut_reset, valid_in, cin, valid_out, carry, zero;
  logic rsp_valid, rsp_carry, rsp_zero, busy, err_timeout, err_spurious;
  logic [CNT_W-1:0] issued_cnt, done_cnt;

  alu_txn_driver #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_cin(cmd_cin), .cmd_ctl(cmd_ctl), .dut_reset(dut_reset),
    .valid_in(valid_in), .cin(cin), .a(a), .b(b), .ctl(ctl),
    .valid_out(valid_out), .carry(carry), .zero(zero), .alu(alu),
    .rsp_valid(rsp_valid), .rsp_alu(rsp_alu), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious),
    .issued_cnt(issued_cnt), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    opcode_e    ctl;
  } tcmd_t;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

  tcmd_t mq[$];
  int m_out, m_wait, m_mode;
  logic e_vin, e_cin, e_rv, e_rc, e_rz, e_et, e_es, e_dr;
  logic [3:0] e_a, e_b, e_ralu;
  opcode_e e_ctl;
  logic [CNT_W-1:0] e_iss, e_done;

  task model_reset();
    mq.delete();
    m_out = 0; m_wait = 0; m_mode = M_IDLE;
    e_vin = 0; e_a = 0; e_b = 0; e_cin = 0; e_ctl = opcode_e'(0);
    e_rv = 0; e_ralu = 0; e_rc = 0; e_rz = 0;
    e_et = 0; e_es = 0; e_dr = 0; e_iss = 0; e_done = 0;
  endtask

  task model_update();
    bit accept, hit, do_pop, matched;
    tcmd_t c;
    if (reset) begin
      model_reset();
      return;
    end
    accept = cmd_valid && (mq.size() < FIFO_DEPTH) && !clear && (m_mode != M_HALT);
    hit    = (m_out > 0) && !valid_out && (m_wait + 1 >= TIMEOUT);
    do_pop = (m_mode == M_RUN) && enable && (mq.size() > 0) && (m_out < MAX_OUT) && !clear && !hit;
    e_dr = clear;
    e_rv = valid_out;
    if (valid_out) begin
      e_ralu = alu; e_rc = carry; e_rz = zero;
    end
    if (clear) begin
      mq.delete();
      m_out = 0; m_wait = 0; m_mode = M_IDLE;
      e_vin = 0; e_et = 0; e_es = 0; e_iss = 0; e_done = 0;
    end else begin
      e_vin = do_pop;
      if (do_pop) begin
        c = mq.pop_front();
        e_a = c.a; e_b = c.b; e_cin = c.cin; e_ctl = c.ctl;
        e_iss = e_iss + 1'b1;
      end
      if (accept) begin
        c.a = cmd_a; c.b = cmd_b; c.cin = cmd_cin; c.ctl = cmd_ctl;
        mq.push_back(c);
      end
      matched = valid_out && (m_out > 0);
      if (valid_out && m_out == 0) e_es = 1;
      if (valid_out) e_done = e_done + 1'b1;
      if (valid_out || m_out == 0) m_wait = 0; else m_wait++;
      if (hit) begin
        m_mode = M_HALT; e_et = 1;
      end else if (m_mode == M_IDLE && enable) m_mode = M_RUN;
      else if (m_mode == M_RUN && !enable) m_mode = (m_out > 0) ? M_DRAIN : M_IDLE;
      else if (m_mode == M_DRAIN) begin
        if (enable) m_mode = M_RUN;
        else if (m_out == 0) m_mode = M_IDLE;
      end
      m_out = m_out + (do_pop ? 1 : 0) - (matched ? 1 : 0);
    end
  endtask

  task compare();
    check("valid_in", valid_in, e_vin);
    check("a", a, e_a);
    check("b", b, e_b);
    check("cin", cin, e_cin);
    check("ctl", 32'(ctl), 32'(e_ctl));
    check("rsp_valid", rsp_valid, e_rv);
    check("rsp_alu", rsp_alu, e_ralu);
    check("rsp_carry", rsp_carry, e_rc);
    check("rsp_zero", rsp_zero, e_rz);
    check("err_timeout", err_timeout, e_et);
    check("err_spurious", err_spurious, e_es);
    check("issued_cnt", issued_cnt, e_iss);
    check("done_cnt", done_cnt, e_done);
    check("busy", busy, (m_mode == M_RUN) || (m_mode == M_DRAIN) || (m_out > 0));
    check("cmd_ready", cmd_ready, (mq.size() < FIFO_DEPTH) && !clear && (m_mode != M_HALT));
    check("dut_reset", dut_reset, reset || e_dr);
  endtask

  // ---------------- ALU responder and observation ----------------
  bit auto_rsp = 0;
  int lat = 2;
  int rq_t[$];
  logic [4:0] rq_v[$];
  int cyc = 0;
  int pulses = 0, rsp_pulses = 0;
  logic [3:0] last_rsp;
  logic [3:0] seen_a[$], seen_b[$];
  int seen_t[$];

  task tick();
    logic [4:0] s;
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    compare();
    if (valid_in) begin
      pulses++;
      seen_a.push_back(a); seen_b.push_back(b); seen_t.push_back(cyc);
    end
    if (rsp_valid) begin
      rsp_pulses++; last_rsp = rsp_alu;
    end
    if (auto_rsp) begin
      valid_out = 0;
      foreach (rq_t[i]) rq_t[i]--;
      if (rq_t.size() > 0 && rq_t[0] <= 0) begin
        void'(rq_t.pop_front());
        s = rq_v.pop_front();
        valid_out = 1; alu = s[3:0]; carry = s[4]; zero = (s[3:0] == 4'h0);
      end
      if (valid_in) begin
        rq_t.push_back(lat);
        rq_v.push_back(5'(a) + 5'(b) + 5'(cin));
      end
    end
  endtask

  task ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task push(input logic [3:0] pa, input logic [3:0] pb, input logic pc, input opcode_e op);
    bit acc;
    acc = 0;
    cmd_a = pa; cmd_b = pb; cmd_cin = pc; cmd_ctl = op; cmd_valid = 1;
    for (int i = 0; i < 50; i++) begin
      acc = cmd_ready;
      tick();
      if (acc) break;
    end
    cmd_valid = 0;
    check("push_accepted", acc, 1'b1);
  endtask

  task respond(input logic [3:0] v, input logic c);
    valid_out = 1; alu = v; carry = c; zero = (v == 4'h0);
    tick();
    valid_out = 0;
  endtask

  task reset_obs();
    pulses = 0; rsp_pulses = 0;
    seen_a.delete(); seen_b.delete(); seen_t.delete();
  endtask

  int t_e;

  initial begin
    reset = 1; enable = 0; clear = 0; cmd_valid = 0;
    cmd_a = 0; cmd_b = 0; cmd_cin = 0; cmd_ctl = OP_ADD;
    valid_out = 0; alu = 0; carry = 0; zero = 0;
    model_reset();
    ticks(2);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_dut_reset", dut_reset, 1'b1);
    check("rst_valid_in", valid_in, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 0;
    ticks(2);

    // basic issue with a 2-cycle ALU
    reset_obs();
    enable = 1; auto_rsp = 1; lat = 2;
    push(4'd3, 4'd5, 1'b0, opcode_e'(0));
    ticks(8);
    check("basic_pulses", pulses, 1);
    check("basic_a", seen_a.size() > 0 ? seen_a[0] : 4'hx, 4'd3);
    check("basic_b", seen_b.size() > 0 ? seen_b[0] : 4'hx, 4'd5);
    check("basic_rsp_pulses", rsp_pulses, 1);
    check("basic_rsp_alu", last_rsp, 4'd8);
    check("basic_issued", issued_cnt, 1);
    check("basic_done", done_cnt, 1);
    enable = 0;
    ticks(2);
    check("basic_busy", busy, 1'b0);

    // throttle at MAX_OUT with a silent ALU
    auto_rsp = 0; enable = 1;
    ticks(1);
    reset_obs();
    for (int i = 0; i < 6; i++) push(4'(i), 4'(i + 1), 1'b0, OP_SUB);
    ticks(3);
    check("throttle_stall", pulses, 4);
    respond(4'h1, 1'b0);
    ticks(2);
    respond(4'h2, 1'b0);
    ticks(3);
    check("throttle_total", pulses, 6);
    for (int i = 0; i < 4; i++) begin
      respond(4'(i), 1'b1);
      tick();
    end
    enable = 0;
    ticks(3);
    check("throttle_issued", issued_cnt, 7);
    check("throttle_done", done_cnt, 7);
    check("throttle_spurious", err_spurious, 1'b0);

    // issue and response in the same cycle
    enable = 1;
    tick();
    push(4'hC, 4'h1, 1'b1, OP_AND);
    tick();
    push(4'hD, 4'h2, 1'b0, OP_OR);
    valid_out = 1; alu = 4'h5; carry = 0; zero = 0;
    tick();
    valid_out = 0;
    tick();
    respond(4'h6, 1'b0);
    ticks(2);
    enable = 0;
    ticks(3);
    check("same_cycle_busy", busy, 1'b0);
    check("same_cycle_spurious", err_spurious, 1'b0);
    check("same_cycle_issued", issued_cnt, 9);
    check("same_cycle_done", done_cnt, 9);

    // full FIFO, then back-to-back drain in order
    ticks(1);
    for (int i = 1; i <= 4; i++) push(4'(i), 4'(i), 1'b0, OP_XOR);
    check("full_ready", cmd_ready, 1'b0);
    cmd_a = 4'd5; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    reset_obs();
    enable = 1;
    ticks(8);
    check("full_pulses", pulses, 4);
    for (int i = 0; i < 4 && i < seen_a.size(); i++) begin
      check("full_order", seen_a[i], 4'(i + 1));
      check("full_b2b", seen_t[i] - seen_t[0], i);
    end
    for (int i = 0; i < 4; i++) respond(4'(i), 1'b0);
    ticks(4);
    check("full_no_fifth", pulses, 4);

    // watchdog timeout
    reset_obs();
    push(4'd7, 4'd1, 1'b0, OP_ADD);
    ticks(2);
    t_e = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (err_timeout) begin
        t_e = cyc;
        break;
      end
    end
    check("timeout_seen", t_e >= 0, 1'b1);
    check("timeout_delay", seen_t.size() > 0 ? t_e - seen_t[0] : -1, 16);
    check("timeout_ready", cmd_ready, 1'b0);
    cmd_valid = 1; cmd_a = 4'd9;
    tick();
    cmd_valid = 0;
    ticks(3);
    check("timeout_no_issue", pulses, 1);
    enable = 0; clear = 1;
    tick();
    clear = 0;
    check("clear_dut_reset_hi", dut_reset, 1'b1);
    check("clear_err_timeout", err_timeout, 1'b0);
    tick();
    check("clear_dut_reset_lo", dut_reset, 1'b0);
    check("clear_busy", busy, 1'b0);
    check("clear_issued", issued_cnt, 0);

    // spurious response while idle
    respond(4'hA, 1'b1);
    check("spur_flag", err_spurious, 1'b1);
    check("spur_rsp_valid", rsp_valid, 1'b1);
    check("spur_rsp_alu", rsp_alu, 4'hA);
    tick();
    check("spur_busy", busy, 1'b0);
    check("spur_done", done_cnt, 1);
    clear = 1;
    tick();
    clear = 0;
    tick();

    // async reset in the middle of a burst
    enable = 1; auto_rsp = 1; lat = 3;
    tick();
    push(4'd1, 4'd1, 1'b0, OP_ADD);
    push(4'd2, 4'd2, 1'b0, OP_ADD);
    push(4'd3, 4'd3, 1'b0, OP_ADD);
    tick();
    #2 reset = 1;
    #1;
    check("arst_valid_in", valid_in, 1'b0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_issued", issued_cnt, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", cmd_ready, 1'b1);
    check("arst_dut_reset", dut_reset, 1'b1);
    check("arst_a", a, 4'd0);
    model_reset();
    ticks(2);
    reset = 0;
    reset_obs();
    ticks(6);
    check("arst_fifo_empty", pulses, 0);
    check("arst_ready_after", cmd_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
